node_network_interface: RTL and testbench

Parametrised network interface between a node's processor core and the photonic interconnect. It filters and queues incoming control packets, queues incoming data packets tagged with their source node, and transmits processor-queued data packets in a time-division slot owned by this node. It sits directly under the `computer` top level, between the core and the network-facing packet ports.

---
 rtl/nni_pkg.sv | 33 +++
 rtl/node_network_interface_if.sv | 47 ++++
 rtl/nni_sync_fifo.sv | 60 ++++++
 rtl/node_network_interface.sv | 134 +++++++++++++
 tb/tb_node_network_interface.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nni_pkg.sv
// ============================================================================
// Module      : nni_pkg
// Description : Shared constants and packet field helpers for the node
//               network interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nni_pkg;

    localparam int NNI_MAX_W = 256;

    typedef logic [NNI_MAX_W-1:0] nni_word_t;

    localparam nni_word_t NNI_IDLE_PKT = '0;
    localparam nni_word_t NNI_BCAST_ID = '1;

    // Packets are zero-extended into a wide word so one helper serves any width pair.
    function automatic nni_word_t nni_header(input nni_word_t pkt, input int pkt_w, input int id_w);
        nni_word_t mask;
        mask = (nni_word_t'(1) << id_w) - nni_word_t'(1);
        return (pkt >> (pkt_w - id_w)) & mask;
    endfunction

    function automatic nni_word_t nni_payload(input nni_word_t pkt, input int pkt_w, input int id_w);
        nni_word_t mask;
        mask = (nni_word_t'(1) << (pkt_w - id_w)) - nni_word_t'(1);
        return pkt & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/node_network_interface_if.sv
// ============================================================================
// Module      : node_network_interface_if
// Description : Core-side and network-side signal bundle of the node network
//               interface; slave is the interface block, master its environment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface node_network_interface_if #(
    parameter int PKT_W = 32,
    parameter int ID_W  = 16
);
    logic [ID_W-1:0]       node_id;
    logic [ID_W-1:0]       max_node;
    logic [PKT_W-1:0]      control_rx_packet;
    logic [PKT_W-1:0]      control_tx_packet;
    logic [ID_W-1:0]       data_rx_node_id;
    logic [PKT_W-1:0]      data_rx_packet;
    logic [PKT_W-1:0]      data_tx_packet;
    logic                  crx_rd;
    logic                  crx_valid;
    logic [PKT_W-ID_W-1:0] crx_data;
    logic                  drx_rd;
    logic                  drx_valid;
    logic [ID_W+PKT_W-1:0] drx_data;
    logic                  tx_wr;
    logic [PKT_W-1:0]      tx_data;
    logic                  tx_full;
    logic                  rx_drop;

    modport slave (
        input  node_id, max_node, control_rx_packet, data_rx_node_id, data_rx_packet,
               crx_rd, drx_rd, tx_wr, tx_data,
        output control_tx_packet, data_tx_packet, crx_valid, crx_data,
               drx_valid, drx_data, tx_full, rx_drop
    );

    modport master (
        output node_id, max_node, control_rx_packet, data_rx_node_id, data_rx_packet,
               crx_rd, drx_rd, tx_wr, tx_data,
        input  control_tx_packet, data_tx_packet, crx_valid, crx_data,
               drx_valid, drx_data, tx_full, rx_drop
    );

endinterface

`default_nettype wire

// File: rtl/nni_sync_fifo.sv
// ============================================================================
// Module      : nni_sync_fifo
// Description : First-word fall-through synchronous FIFO with full/empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nni_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             w_do_wr;
    logic             w_do_rd;

    // Extra pointer bit distinguishes full from empty when the addresses match.
    assign o_empty   = (wr_ptr_q == rd_ptr_q);
    assign o_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_do_rd   = i_rd && !o_empty;
    assign w_do_wr   = i_wr && (!o_full || w_do_rd);
    assign o_rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(w_do_wr);
        rd_ptr_d = rd_ptr_q + (AW+1)'(w_do_rd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_wr_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/node_network_interface.sv
// ============================================================================
// Module      : node_network_interface
// Description : Filters/queues control and data packets from the interconnect
//               and transmits queued data packets in this node's TDM slot.
//               Optional: NNI_BROADCAST_EN accepts all-ones control headers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module node_network_interface
    import nni_pkg::*;
#(
    parameter int PKT_W     = 32,
    parameter int ID_W      = 16,
    parameter int CRX_DEPTH = 4,
    parameter int DRX_DEPTH = 4,
    parameter int TX_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    node_network_interface_if.slave nif
);

    localparam int PL_W = PKT_W - ID_W;

    logic [ID_W-1:0]       w_ctl_hdr;
    logic [PL_W-1:0]       w_ctl_pl;
    logic                  w_ctl_live;
    logic                  w_ctl_own;
    logic                  w_ctl_acc;
    logic                  w_ctl_ack;
    logic                  w_drx_acc;
    logic                  w_crx_full, w_crx_empty, w_crx_drop;
    logic                  w_drx_full, w_drx_empty, w_drx_drop;
    logic                  w_tx_empty, w_tx_pop;
    logic [PKT_W-1:0]      w_tx_head;
    logic [PL_W-1:0]       w_crx_head;
    logic [ID_W+PKT_W-1:0] w_drx_head;
    logic [ID_W-1:0]       w_max_eff;

    logic [ID_W-1:0]  slot_q, slot_d;
    logic [PKT_W-1:0] ack_q, ack_d;
    logic [PKT_W-1:0] dtx_q, dtx_d;
    logic             drop_q, drop_d;

    assign w_ctl_hdr  = ID_W'(nni_header(nni_word_t'(nif.control_rx_packet), PKT_W, ID_W));
    assign w_ctl_pl   = PL_W'(nni_payload(nni_word_t'(nif.control_rx_packet), PKT_W, ID_W));
    assign w_ctl_live = (nif.control_rx_packet != PKT_W'(NNI_IDLE_PKT));
    assign w_ctl_own  = (w_ctl_hdr == nif.node_id);

`ifdef NNI_BROADCAST_EN
    logic w_ctl_bcast;
    assign w_ctl_bcast = (w_ctl_hdr == ID_W'(NNI_BCAST_ID));
    assign w_ctl_acc   = w_ctl_live && (w_ctl_own || w_ctl_bcast);
    assign w_ctl_ack   = w_ctl_live && w_ctl_own && !w_ctl_bcast;
`else
    assign w_ctl_acc   = w_ctl_live && w_ctl_own;
    assign w_ctl_ack   = w_ctl_acc;
`endif

    assign w_drx_acc  = (nif.data_rx_packet != PKT_W'(NNI_IDLE_PKT)) && (nif.data_rx_node_id != '0);

    // A same-cycle pop frees the slot, so only a push into a full FIFO without a pop is lost.
    assign w_crx_drop = w_ctl_acc && w_crx_full && !nif.crx_rd;
    assign w_drx_drop = w_drx_acc && w_drx_full && !nif.drx_rd;

    assign w_max_eff  = (nif.max_node == '0) ? ID_W'(1) : nif.max_node;
    assign w_tx_pop   = (slot_q == nif.node_id) && !w_tx_empty;

    always_comb begin
        slot_d = (slot_q >= w_max_eff) ? ID_W'(1) : slot_q + ID_W'(1);
        ack_d  = w_ctl_ack ? {nif.node_id, PL_W'(0)} : '0;
        dtx_d  = w_tx_pop ? w_tx_head : '0;
        drop_d = w_crx_drop || w_drx_drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= ID_W'(1);
            ack_q  <= '0;
            dtx_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            slot_q <= slot_d;
            ack_q  <= ack_d;
            dtx_q  <= dtx_d;
            drop_q <= drop_d;
        end
    end

    nni_sync_fifo #(.WIDTH(PL_W), .DEPTH(CRX_DEPTH)) u_crx_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr      (w_ctl_acc),
        .i_wr_data (w_ctl_pl),
        .i_rd      (nif.crx_rd),
        .o_rd_data (w_crx_head),
        .o_full    (w_crx_full),
        .o_empty   (w_crx_empty)
    );

    nni_sync_fifo #(.WIDTH(ID_W+PKT_W), .DEPTH(DRX_DEPTH)) u_drx_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr      (w_drx_acc),
        .i_wr_data ({nif.data_rx_node_id, nif.data_rx_packet}),
        .i_rd      (nif.drx_rd),
        .o_rd_data (w_drx_head),
        .o_full    (w_drx_full),
        .o_empty   (w_drx_empty)
    );

    nni_sync_fifo #(.WIDTH(PKT_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr      (nif.tx_wr),
        .i_wr_data (nif.tx_data),
        .i_rd      (w_tx_pop),
        .o_rd_data (w_tx_head),
        .o_full    (nif.tx_full),
        .o_empty   (w_tx_empty)
    );

    assign nif.control_tx_packet = ack_q;
    assign nif.data_tx_packet    = dtx_q;
    assign nif.rx_drop           = drop_q;
    assign nif.crx_valid         = !w_crx_empty;
    assign nif.crx_data          = w_crx_head;
    assign nif.drx_valid         = !w_drx_empty;
    assign nif.drx_data          = w_drx_head;

endmodule

`default_nettype wire

// File: tb/tb_node_network_interface.sv
// ============================================================================
// Module      : tb_node_network_interface
// Description : Self-checking bench for node_network_interface against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_node_network_interface;

    localparam int PKT_W = 32;
    localparam int ID_W  = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    node_network_interface_if #(.PKT_W(PKT_W), .ID_W(ID_W)) nif ();

    node_network_interface #(
        .PKT_W(PKT_W), .ID_W(ID_W),
        .CRX_DEPTH(DEPTH), .DRX_DEPTH(DEPTH), .TX_DEPTH(DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .nif (nif)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: queues plus a cycle count since reset release.
    logic [15:0] m_crx [$];
    logic [47:0] m_drx [$];
    logic [31:0] m_tx  [$];
    int          m_k = 0;
    logic [31:0] m_ctl = '0;
    logic [31:0] m_dtx = '0;
    logic        m_drop = 1'b0;

    task automatic idle_inputs();
        nif.control_rx_packet = '0;
        nif.data_rx_node_id   = '0;
        nif.data_rx_packet    = '0;
        nif.crx_rd            = 1'b0;
        nif.drx_rd            = 1'b0;
        nif.tx_wr             = 1'b0;
        nif.tx_data           = '0;
    endtask

    task automatic tick();
        logic [31:0] cp, dp, td;
        logic [15:0] did, nid, mx;
        logic        r, crd, drd, twr;
        int          eff;
        r = rst; cp = nif.control_rx_packet; dp = nif.data_rx_packet; did = nif.data_rx_node_id;
        nid = nif.node_id; mx = nif.max_node; crd = nif.crx_rd; drd = nif.drx_rd;
        twr = nif.tx_wr; td = nif.tx_data;
        @(posedge clk);
        #1;
        if (r) begin
            m_crx.delete(); m_drx.delete(); m_tx.delete();
            m_k = 0; m_ctl = '0; m_dtx = '0; m_drop = 1'b0;
        end else begin
            eff    = (mx == 16'h0) ? 1 : int'(mx);
            m_drop = 1'b0;
            if (crd && m_crx.size() > 0) void'(m_crx.pop_front());
            if (cp != 32'h0 && cp[31:16] == nid) begin
                if (m_crx.size() < DEPTH) m_crx.push_back(cp[15:0]); else m_drop = 1'b1;
                m_ctl = {nid, 16'h0};
            end else begin
                m_ctl = '0;
            end
            if (drd && m_drx.size() > 0) void'(m_drx.pop_front());
            if (dp != 32'h0 && did != 16'h0) begin
                if (m_drx.size() < DEPTH) m_drx.push_back({did, dp}); else m_drop = 1'b1;
            end
            m_dtx = '0;
            if (((m_k % eff) + 1) == int'(nid) && m_tx.size() > 0) m_dtx = m_tx.pop_front();
            if (twr && m_tx.size() < DEPTH) m_tx.push_back(td);
            m_k++;
        end
    endtask

    task automatic do_reset(input logic [15:0] nid, input logic [15:0] mx);
        idle_inputs();
        nif.node_id  = nid;
        nif.max_node = mx;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [131:0] obs_vec();
        return {nif.control_tx_packet, nif.data_tx_packet,
                nif.crx_valid, (nif.crx_valid ? nif.crx_data : 16'h0),
                nif.drx_valid, (nif.drx_valid ? nif.drx_data : 48'h0),
                nif.tx_full, nif.rx_drop};
    endfunction

    function automatic logic [131:0] exp_vec();
        return {m_ctl, m_dtx,
                (m_crx.size() > 0), (m_crx.size() > 0 ? m_crx[0] : 16'h0),
                (m_drx.size() > 0), (m_drx.size() > 0 ? m_drx[0] : 48'h0),
                (m_tx.size() == DEPTH), m_drop};
    endfunction

    task automatic test_reset();
        nif.node_id = 16'd1; nif.max_node = 16'd4;
        nif.control_rx_packet = 32'h0001_1234; nif.data_rx_node_id = 16'd2;
        nif.data_rx_packet = 32'hCAFE_0001; nif.tx_wr = 1'b1; nif.tx_data = 32'h1111_2222;
        nif.crx_rd = 1'b0; nif.drx_rd = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (nif.control_tx_packet !== 32'h0) $display("FAIL reset_ctl_tx: got %h want 0", nif.control_tx_packet); else n_pass++;
        n_checks++; if (nif.data_tx_packet !== 32'h0) $display("FAIL reset_data_tx: got %h want 0", nif.data_tx_packet); else n_pass++;
        n_checks++; if (nif.crx_valid !== 1'b0) $display("FAIL reset_crx_valid: got %b want 0", nif.crx_valid); else n_pass++;
        n_checks++; if (nif.drx_valid !== 1'b0) $display("FAIL reset_drx_valid: got %b want 0", nif.drx_valid); else n_pass++;
        n_checks++; if (nif.tx_full !== 1'b0) $display("FAIL reset_tx_full: got %b want 0", nif.tx_full); else n_pass++;
        n_checks++; if (nif.rx_drop !== 1'b0) $display("FAIL reset_rx_drop: got %b want 0", nif.rx_drop); else n_pass++;
    endtask

    task automatic test_control_accept();
        do_reset(16'd1, 16'd4);
        nif.control_rx_packet = 32'h0001_FFFF;
        tick();
        n_checks++; if (nif.crx_valid !== 1'b1) $display("FAIL ctl_valid: got %b want 1", nif.crx_valid); else n_pass++;
        n_checks++; if (nif.crx_data !== 16'hFFFF) $display("FAIL ctl_data: got %h want ffff", nif.crx_data); else n_pass++;
        n_checks++; if (nif.control_tx_packet !== 32'h0001_0000) $display("FAIL ctl_ack: got %h want 00010000", nif.control_tx_packet); else n_pass++;
        nif.control_rx_packet = 32'h0002_FFFF;
        tick();
        n_checks++; if (nif.control_tx_packet !== 32'h0) $display("FAIL ctl_ack_one_cycle: got %h want 0", nif.control_tx_packet); else n_pass++;
        nif.control_rx_packet = '0;
        nif.crx_rd = 1'b1;
        tick();
        nif.crx_rd = 1'b0;
        n_checks++; if (nif.crx_valid !== 1'b0) $display("FAIL ctl_foreign_ignored: got %b want 0", nif.crx_valid); else n_pass++;
    endtask

    task automatic test_crx_overflow();
        do_reset(16'd1, 16'd4);
        for (int i = 1; i <= 5; i++) begin
            nif.control_rx_packet = {16'h0001, 16'(i)};
            tick();
            n_checks++; if (nif.rx_drop !== (i == 5)) $display("FAIL ovf_drop_%0d: got %b want %b", i, nif.rx_drop, (i == 5)); else n_pass++;
        end
        nif.control_rx_packet = '0;
        tick();
        n_checks++; if (nif.rx_drop !== 1'b0) $display("FAIL ovf_drop_pulse: got %b want 0", nif.rx_drop); else n_pass++;
        for (int i = 1; i <= 4; i++) begin
            n_checks++; if (nif.crx_valid !== 1'b1 || nif.crx_data !== 16'(i)) $display("FAIL ovf_order_%0d: got %b/%h want 1/%h", i, nif.crx_valid, nif.crx_data, 16'(i)); else n_pass++;
            nif.crx_rd = 1'b1;
            tick();
            nif.crx_rd = 1'b0;
        end
        n_checks++; if (nif.crx_valid !== 1'b0) $display("FAIL ovf_drained: got %b want 0", nif.crx_valid); else n_pass++;
    endtask

    task automatic test_tdm();
        logic [31:0] vals [$];
        int          hits [$];
        int          slot_before;
        do_reset(16'd3, 16'd4);
        nif.tx_wr = 1'b1; nif.tx_data = 32'hA5A5_0001;
        tick();
        nif.tx_data = 32'hA5A5_0002;
        tick();
        nif.tx_wr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            slot_before = ((2 + i) % 4) + 1;
            tick();
            if (nif.data_tx_packet !== 32'h0) begin
                vals.push_back(nif.data_tx_packet);
                hits.push_back(2 + i);
                n_checks++; if (slot_before != 3) $display("FAIL tdm_slot: output after slot %0d want 3", slot_before); else n_pass++;
            end
        end
        n_checks++; if (hits.size() != 2) $display("FAIL tdm_count: got %0d want 2", hits.size()); else n_pass++;
        if (hits.size() == 2) begin
            n_checks++; if (vals[0] !== 32'hA5A5_0001) $display("FAIL tdm_first: got %h want a5a50001", vals[0]); else n_pass++;
            n_checks++; if (vals[1] !== 32'hA5A5_0002) $display("FAIL tdm_second: got %h want a5a50002", vals[1]); else n_pass++;
            n_checks++; if (hits[1] - hits[0] != 4) $display("FAIL tdm_gap: got %0d want 4", hits[1] - hits[0]); else n_pass++;
        end
    endtask

    task automatic test_data_rx();
        do_reset(16'd1, 16'd4);
        nif.data_rx_node_id = 16'd2; nif.data_rx_packet = 32'hDEAD_0001;
        tick();
        n_checks++; if (nif.drx_valid !== 1'b1) $display("FAIL drx_valid: got %b want 1", nif.drx_valid); else n_pass++;
        n_checks++; if (nif.drx_data !== {16'h0002, 32'hDEAD_0001}) $display("FAIL drx_tag: got %h want 0002dead0001", nif.drx_data); else n_pass++;
        nif.data_rx_packet = '0; nif.drx_rd = 1'b1;
        tick();
        nif.drx_rd = 1'b0;
        n_checks++; if (nif.drx_valid !== 1'b0) $display("FAIL drx_zero_pkt: got %b want 0", nif.drx_valid); else n_pass++;
        nif.data_rx_node_id = 16'd0; nif.data_rx_packet = 32'h1234_5678;
        tick();
        n_checks++; if (nif.drx_valid !== 1'b0) $display("FAIL drx_zero_id: got %b want 0", nif.drx_valid); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_full_plus_pop();
        logic [31:0] order [4];
        do_reset(16'd1, 16'd4);
        nif.data_rx_node_id = 16'd5;
        for (int i = 0; i < 4; i++) begin
            nif.data_rx_packet = 32'h100 + 32'(i);
            tick();
        end
        nif.data_rx_packet = 32'h200; nif.drx_rd = 1'b1;
        tick();
        n_checks++; if (nif.rx_drop !== 1'b0) $display("FAIL fpp_no_drop: got %b want 0", nif.rx_drop); else n_pass++;
        n_checks++; if (nif.drx_data !== {16'd5, 32'h101}) $display("FAIL fpp_head: got %h want 000500000101", nif.drx_data); else n_pass++;
        nif.data_rx_packet = 32'h300; nif.drx_rd = 1'b0;
        tick();
        n_checks++; if (nif.rx_drop !== 1'b1) $display("FAIL fpp_still_full: got %b want 1", nif.rx_drop); else n_pass++;
        nif.data_rx_packet = '0;
        order[0] = 32'h101; order[1] = 32'h102; order[2] = 32'h103; order[3] = 32'h200;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (nif.drx_valid !== 1'b1 || nif.drx_data !== {16'd5, order[i]}) $display("FAIL fpp_order_%0d: got %b/%h want 1/%h", i, nif.drx_valid, nif.drx_data, {16'd5, order[i]}); else n_pass++;
            nif.drx_rd = 1'b1;
            tick();
        end
        nif.drx_rd = 1'b0;
        n_checks++; if (nif.drx_valid !== 1'b0) $display("FAIL fpp_drained: got %b want 0", nif.drx_valid); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_reset_mid_traffic();
        do_reset(16'd3, 16'd5);
        for (int i = 0; i < 2; i++) begin
            nif.control_rx_packet = {16'd3, 16'(8'h11 * (i + 1))};
            nif.data_rx_node_id = 16'd1; nif.data_rx_packet = 32'(i + 1);
            nif.tx_wr = 1'b1; nif.tx_data = 32'hBEEF_0000 + 32'(i);
            tick();
        end
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (obs_vec() !== 132'h0) $display("FAIL rmt_flush: got %h want 0", obs_vec()); else n_pass++;
        nif.tx_wr = 1'b1; nif.tx_data = 32'hC0DE_0001;
        tick();
        nif.tx_wr = 1'b0;
        n_checks++; if (nif.data_tx_packet !== 32'h0) $display("FAIL rmt_slot1: got %h want 0", nif.data_tx_packet); else n_pass++;
        tick();
        n_checks++; if (nif.data_tx_packet !== 32'h0) $display("FAIL rmt_slot2: got %h want 0", nif.data_tx_packet); else n_pass++;
        tick();
        n_checks++; if (nif.data_tx_packet !== 32'hC0DE_0001) $display("FAIL rmt_slot3: got %h want c0de0001", nif.data_tx_packet); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++; if (nif.data_tx_packet !== 32'h0) $display("FAIL rmt_no_stale_%0d: got %h want 0", i, nif.data_tx_packet); else n_pass++;
        end
    endtask

    task automatic test_random(input logic [15:0] nid, input logic [15:0] mx, input int cycles);
        do_reset(nid, mx);
        for (int c = 0; c < cycles; c++) begin
            case ($urandom_range(0, 3))
                0:       nif.control_rx_packet = '0;
                1:       nif.control_rx_packet = {nid, 16'($urandom)};
                2:       nif.control_rx_packet = 32'($urandom);
                default: nif.control_rx_packet = {nid, 16'h0};
            endcase
            nif.data_rx_node_id = 16'($urandom_range(0, 3));
            nif.data_rx_packet  = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
            nif.crx_rd  = ($urandom_range(0, 2) == 0);
            nif.drx_rd  = ($urandom_range(0, 2) == 0);
            nif.tx_wr   = ($urandom_range(0, 1) == 1) && (m_tx.size() < DEPTH);
            nif.tx_data = 32'($urandom) | 32'h1;
            tick();
            n_checks++; if (obs_vec() !== exp_vec()) $display("FAIL rand_n%0d_m%0d_c%0d: got %h want %h", nid, mx, c, obs_vec(), exp_vec()); else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        nif.node_id = 16'd1;
        nif.max_node = 16'd4;
        test_reset();
        test_control_accept();
        test_crx_overflow();
        test_tdm();
        test_data_rx();
        test_full_plus_pop();
        test_reset_mid_traffic();
        test_random(16'd2, 16'd4, 400);
        test_random(16'd1, 16'd0, 200);
        begin
            logic [15:0] mx;
            mx = 16'($urandom_range(1, 6));
            test_random(16'($urandom_range(1, int'(mx))), mx, 400);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
